// File: rtl/fire_expand_ctrl.sv
// fire_expand_ctrl: sequencer for one fire-expand MAC array layer.
// It walks the weight-ROM address through every tap of each output pixel.
// It waits PIPE_LAT cycles for the MAC pipeline to drain, then strobes
// mac_clr and ofm_capture together. After the last pixel it raises the
// sticky layer_end flag.
//
// State table:
//   IDLE    | waiting for the first start after reset
//   ACCUM   | consuming one tap per accepted ifm word
//   DRAIN   | letting the last product reach the accumulator
//   CAPTURE | one-cycle accumulator clear and output capture
//   DONE    | layer finished; layer_end held until the next start
//
// Build option FIRE_CTRL_STALL_EN: when defined, ifm_valid gates tap
// consumption. When undefined, ACCUM never stalls and the layer timing
// is fixed.

module fire_expand_ctrl #(
    parameter int KERNEL_DIM = 3,
    parameter int CHIN       = 64,
    parameter int OUT_PIXELS = 256,
    parameter int PIPE_LAT   = 2,
    parameter int AW         = $clog2(KERNEL_DIM * KERNEL_DIM * CHIN),
    parameter int PW         = $clog2(OUT_PIXELS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ifm_valid,
    output logic          ifm_ready,
    output logic [AW-1:0] weight_addr,
    output logic          mac_clr,
    output logic          ofm_capture,
    output logic [PW-1:0] pixel_count,
    output logic          busy,
    output logic          layer_end
);

    localparam int TAPS = KERNEL_DIM * KERNEL_DIM * CHIN;
    // Keep the drain counter at least one bit wide so PIPE_LAT=0 still elaborates.
    localparam int DW = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

    localparam logic [AW-1:0] LAST_TAP   = AW'(TAPS - 1);
    localparam logic [PW-1:0] PIX_MAX    = PW'(OUT_PIXELS);
    localparam logic [DW-1:0] DRAIN_LOAD = (PIPE_LAT > 0) ? DW'(PIPE_LAT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t        state;
    logic [DW-1:0] drain_cnt;
    logic          tap_take;
    logic [PW-1:0] pix_next;

    // Decide whether the current ACCUM cycle consumes a tap.
`ifdef FIRE_CTRL_STALL_EN
    assign tap_take = ifm_valid;
`else
    // ifm_valid is absorbed here so the port stays connected and read;
    // the result is always 1, so ACCUM never stalls.
    assign tap_take = ifm_valid | 1'b1;
`endif

    // Next pixel count, saturating at OUT_PIXELS so it never wraps within a layer.
    assign pix_next = (pixel_count == PIX_MAX) ? PIX_MAX : pixel_count + PW'(1);

    // Layer sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            drain_cnt   <= '0;
            ifm_ready   <= 1'b0;
            weight_addr <= '0;
            mac_clr     <= 1'b0;
            ofm_capture <= 1'b0;
            pixel_count <= '0;
            busy        <= 1'b0;
            layer_end   <= 1'b0;
        end else begin
            mac_clr     <= 1'b0;
            ofm_capture <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_ACCUM;
                        weight_addr <= '0;
                        pixel_count <= '0;
                        layer_end   <= 1'b0;
                        busy        <= 1'b1;
                        ifm_ready   <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (tap_take) begin
                        if (weight_addr == LAST_TAP) begin
                            weight_addr <= '0;
                            ifm_ready   <= 1'b0;
                            if (PIPE_LAT == 0) begin
                                state       <= S_CAPTURE;
                                mac_clr     <= 1'b1;
                                ofm_capture <= 1'b1;
                            end else begin
                                state     <= S_DRAIN;
                                drain_cnt <= DRAIN_LOAD;
                            end
                        end else begin
                            weight_addr <= weight_addr + AW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state       <= S_CAPTURE;
                        mac_clr     <= 1'b1;
                        ofm_capture <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                S_CAPTURE: begin
                    pixel_count <= pix_next;
                    if (pix_next == PIX_MAX) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        layer_end <= 1'b1;
                    end else begin
                        state     <= S_ACCUM;
                        ifm_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    ifm_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
